// File: rtl/alu_pkg.sv
// Shared ALU encodings plus status-word layout and branch condition codes
// used by the flag register and any stage that evaluates branch conditions.
package alu_pkg;

    typedef enum logic [2:0] {
        FUNC_ADD  = 3'd0,
        FUNC_SUB  = 3'd1,
        FUNC_AND  = 3'd2,
        FUNC_OR   = 3'd3,
        FUNC_XOR  = 3'd4,
        FUNC_INV  = 3'd5,
        FUNC_PASS = 3'd6,
        FUNC_NOP  = 3'd7
    } alu_func_e;

    typedef enum logic [2:0] {
        BR_ALWAYS = 3'd0,
        BR_EQ     = 3'd1,
        BR_NE     = 3'd2,
        BR_POS    = 3'd3,
        BR_NEG    = 3'd4,
        BR_CS     = 3'd5,
        BR_CC     = 3'd6,
        BR_VS     = 3'd7
    } branch_cond_e;

    localparam int STATUS_W = 5;
    localparam int STAT_Z   = 0;
    localparam int STAT_P   = 1;
    localparam int STAT_C   = 2;
    localparam int STAT_V   = 3;
    localparam int STAT_SV  = 4;

    // True for the functions that produce meaningful carry/overflow.
    function automatic logic is_arith(input alu_func_e func);
        return (func == FUNC_ADD) || (func == FUNC_SUB);
    endfunction

    // True for bitwise functions: zero/pos are valid, carry/ovf are not.
    function automatic logic is_logic(input alu_func_e func);
        return (func == FUNC_AND) || (func == FUNC_OR) ||
               (func == FUNC_XOR) || (func == FUNC_INV);
    endfunction

endpackage

// File: rtl/alu_status_reg_branch_cond_eval.sv
// Combinational branch condition evaluator over a held status word; kept
// standalone so the fetch stage can instantiate its own copy.
module branch_cond_eval
    import alu_pkg::*;
(
    input  logic [STATUS_W-1:0] status_word,
    input  logic                flags_valid,
    input  branch_cond_e        branch_cond,
    output logic                branch_taken
);

    logic cond_s;

    // Decode the condition; before any flag write only ALWAYS may be taken.
    always_comb begin
        cond_s = 1'b0;
        case (branch_cond)
            BR_ALWAYS: cond_s = 1'b1;
            BR_EQ:     cond_s = status_word[STAT_Z];
            BR_NE:     cond_s = ~status_word[STAT_Z];
            BR_POS:    cond_s = status_word[STAT_P] & ~status_word[STAT_Z];
            BR_NEG:    cond_s = ~status_word[STAT_P];
            BR_CS:     cond_s = status_word[STAT_C];
            BR_CC:     cond_s = ~status_word[STAT_C];
            BR_VS:     cond_s = status_word[STAT_V];
            default:   cond_s = 1'b0;
        endcase

        if (branch_cond == BR_ALWAYS) begin
            branch_taken = 1'b1;
        end else if (flags_valid) begin
            branch_taken = cond_s;
        end else begin
            branch_taken = 1'b0;
        end
    end

endmodule

// File: rtl/alu_status_reg.sv
// Architectural flag register behind the ALU: latches flags on executing
// cycles, keeps a sticky overflow bit, and exposes a software status word.
module alu_status_reg
    import alu_pkg::*;
#(
    parameter bit STICKY_OVF_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  alu_func_e           alu_func,
    input  logic                flag_update_en,
    input  logic                zero_flag,
    input  logic                positive_flag,
    input  logic                carry_flag,
    input  logic                signed_overflow,
    input  logic                sw_write_en,
    input  logic [STATUS_W-1:0] sw_write_data,
    input  branch_cond_e        branch_cond,
    output logic [STATUS_W-1:0] status_word,
    output logic                flags_valid,
    output logic                branch_taken
);

    logic [STATUS_W-1:0] status_r;
    logic [STATUS_W-1:0] status_next_s;
    logic                valid_r;
    logic                valid_next_s;

    // Next-state: software write beats an ALU update in the same cycle.
    always_comb begin
        status_next_s = status_r;
        valid_next_s  = valid_r;

        if (sw_write_en) begin
            status_next_s = sw_write_data;
            valid_next_s  = 1'b1;
        end else if (flag_update_en) begin
            valid_next_s = 1'b1;
            if (is_arith(alu_func)) begin
                status_next_s[STAT_Z] = zero_flag;
                status_next_s[STAT_P] = positive_flag;
                status_next_s[STAT_C] = carry_flag;
                status_next_s[STAT_V] = signed_overflow;
                if (signed_overflow) begin
                    status_next_s[STAT_SV] = 1'b1;
                end else begin
                    status_next_s[STAT_SV] = status_r[STAT_SV];
                end
            end else if (is_logic(alu_func)) begin
                // carry/ovf inputs are X for bitwise ops, so never sample them
                status_next_s[STAT_Z] = zero_flag;
                status_next_s[STAT_P] = positive_flag;
            end else begin
                status_next_s = status_r;
            end
        end else begin
            status_next_s = status_r;
        end

        if (!STICKY_OVF_EN) begin
            status_next_s[STAT_SV] = 1'b0;
        end else begin
            status_next_s[STAT_SV] = status_next_s[STAT_SV];
        end
    end

    // Status and valid registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_r <= {STATUS_W{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            status_r <= status_next_s;
            valid_r  <= valid_next_s;
        end
    end

    assign status_word = status_r;
    assign flags_valid = valid_r;

    branch_cond_eval u_branch_cond_eval (
        .status_word  (status_r),
        .flags_valid  (valid_r),
        .branch_cond  (branch_cond),
        .branch_taken (branch_taken)
    );

endmodule

// File: tb/tb_alu_status_reg.sv
// Directed bench for alu_status_reg: one instance with the sticky bit
// enabled and one with it disabled, driven by the same stimulus.
module tb_alu_status_reg;
    import alu_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    alu_func_e    alu_func;
    logic         flag_update_en;
    logic         zero_flag;
    logic         positive_flag;
    logic         carry_flag;
    logic         signed_overflow;
    logic         sw_write_en;
    logic [4:0]   sw_write_data;
    branch_cond_e branch_cond;
    logic [4:0]   status_a, status_b;
    logic         valid_a, valid_b;
    logic         taken_a, taken_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_status_reg #(.STICKY_OVF_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .alu_func(alu_func), .flag_update_en(flag_update_en),
        .zero_flag(zero_flag), .positive_flag(positive_flag), .carry_flag(carry_flag),
        .signed_overflow(signed_overflow), .sw_write_en(sw_write_en),
        .sw_write_data(sw_write_data), .branch_cond(branch_cond),
        .status_word(status_a), .flags_valid(valid_a), .branch_taken(taken_a)
    );

    alu_status_reg #(.STICKY_OVF_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .alu_func(alu_func), .flag_update_en(flag_update_en),
        .zero_flag(zero_flag), .positive_flag(positive_flag), .carry_flag(carry_flag),
        .signed_overflow(signed_overflow), .sw_write_en(sw_write_en),
        .sw_write_data(sw_write_data), .branch_cond(branch_cond),
        .status_word(status_b), .flags_valid(valid_b), .branch_taken(taken_b)
    );

    task automatic idle();
        rst = 1'b0; flag_update_en = 1'b0; sw_write_en = 1'b0;
        sw_write_data = 5'b00000; alu_func = FUNC_NOP;
        zero_flag = 1'b0; positive_flag = 1'b0; carry_flag = 1'b0; signed_overflow = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic alu_op(input alu_func_e f, input logic z, input logic p,
                          input logic c, input logic v);
        alu_func = f; flag_update_en = 1'b1;
        zero_flag = z; positive_flag = p; carry_flag = c; signed_overflow = v;
        step();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1; sw_write_en = 1'b1; sw_write_data = 5'b11111;
        flag_update_en = 1'b1; alu_func = FUNC_ADD; signed_overflow = 1'b1;
        step();
        total++;
        if (status_a !== 5'b00000) begin bad++; $display("FAIL reset_status_a got=%b exp=00000", status_a); end
        total++;
        if (status_b !== 5'b00000) begin bad++; $display("FAIL reset_status_b got=%b exp=00000", status_b); end
        total++;
        if (valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
        branch_cond = BR_EQ; #1;
        total++;
        if (taken_a !== 1'b0) begin bad++; $display("FAIL reset_eq got=%b exp=0", taken_a); end
        branch_cond = BR_NE; #1;
        total++;
        if (taken_a !== 1'b0) begin bad++; $display("FAIL reset_ne_gated got=%b exp=0", taken_a); end
        branch_cond = BR_ALWAYS; #1;
        total++;
        if (taken_a !== 1'b1) begin bad++; $display("FAIL reset_always got=%b exp=1", taken_a); end
    endtask

    task automatic test_overflow();
        alu_op(FUNC_ADD, 1'b0, 1'b0, 1'b0, 1'b1);   // 7F + 01
        total++;
        if (status_a !== 5'b11000) begin bad++; $display("FAIL ovf_add_a got=%b exp=11000", status_a); end
        total++;
        if (status_b !== 5'b01000) begin bad++; $display("FAIL ovf_add_b got=%b exp=01000", status_b); end
        total++;
        if (valid_a !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b exp=1", valid_a); end
        alu_op(FUNC_SUB, 1'b1, 1'b1, 1'b0, 1'b0);   // 5 - 5
        total++;
        if (status_a !== 5'b10011) begin bad++; $display("FAIL ovf_sub_a got=%b exp=10011", status_a); end
        total++;
        if (status_b !== 5'b00011) begin bad++; $display("FAIL ovf_sub_b got=%b exp=00011", status_b); end
    endtask

    task automatic test_logic_hold();
        alu_op(FUNC_ADD, 1'b1, 1'b1, 1'b1, 1'b0);   // FF + 01
        total++;
        if (status_a !== 5'b10111) begin bad++; $display("FAIL carry_add got=%b exp=10111", status_a); end
        alu_op(FUNC_AND, 1'b0, 1'b1, 1'bx, 1'bx);
        total++;
        if (status_a !== 5'b10110) begin bad++; $display("FAIL and_hold got=%b exp=10110", status_a); end
        total++;
        if ($isunknown(status_a)) begin bad++; $display("FAIL and_no_x got=%b exp=known", status_a); end
        branch_cond = BR_CS; #1;
        total++;
        if (taken_a !== 1'b1) begin bad++; $display("FAIL and_cs_taken got=%b exp=1", taken_a); end
        alu_op(FUNC_PASS, 1'b1, 1'b0, 1'b0, 1'b1);  // non-updating function
        total++;
        if (status_a !== 5'b10110) begin bad++; $display("FAIL pass_hold got=%b exp=10110", status_a); end
    endtask

    task automatic test_sw_priority();
        sw_write_en = 1'b1; sw_write_data = 5'b00001;
        alu_op(FUNC_ADD, 1'b0, 1'b1, 1'b1, 1'b1);
        total++;
        if (status_a !== 5'b00001) begin bad++; $display("FAIL sw_prio_a got=%b exp=00001", status_a); end
        total++;
        if (status_b !== 5'b00001) begin bad++; $display("FAIL sw_prio_b got=%b exp=00001", status_b); end
        sw_write_en = 1'b1; sw_write_data = 5'b10000;
        step();
        total++;
        if (status_a !== 5'b10000) begin bad++; $display("FAIL sw_sticky_a got=%b exp=10000", status_a); end
        total++;
        if (status_b !== 5'b00000) begin bad++; $display("FAIL sw_sticky_b got=%b exp=00000", status_b); end
    endtask

    task automatic test_branch_sweep();
        logic [7:0] exp_zp;   // status 00011: zero=1 pos=1 carry=0 ovf=0
        logic [7:0] exp_v;    // status 01000: zero=0 pos=0 carry=0 ovf=1
        exp_zp = 8'b0100_0011;  // bit index = branch_cond code
        exp_v  = 8'b1101_0101;
        sw_write_en = 1'b1; sw_write_data = 5'b00011;
        step();
        for (int i = 0; i < 8; i++) begin
            branch_cond = branch_cond_e'(i[2:0]); #1;
            total++;
            if (taken_a !== exp_zp[i]) begin
                bad++; $display("FAIL sweep_zp code=%0d got=%b exp=%b", i, taken_a, exp_zp[i]);
            end
        end
        sw_write_en = 1'b1; sw_write_data = 5'b01000;
        step();
        for (int i = 0; i < 8; i++) begin
            branch_cond = branch_cond_e'(i[2:0]); #1;
            total++;
            if (taken_b !== exp_v[i]) begin
                bad++; $display("FAIL sweep_v code=%0d got=%b exp=%b", i, taken_b, exp_v[i]);
            end
        end
    endtask

    task automatic test_reset_clears();
        rst = 1'b1;
        step();
        total++;
        if (status_b !== 5'b00000 || valid_b !== 1'b0) begin
            bad++; $display("FAIL rst_clear got=%b/%b exp=00000/0", status_b, valid_b);
        end
        branch_cond = BR_NE; #1;
        total++;
        if (taken_b !== 1'b0) begin bad++; $display("FAIL rst_ne_gated got=%b exp=0", taken_b); end
    endtask

    initial begin
        idle();
        branch_cond = BR_ALWAYS;
        test_reset();
        test_overflow();
        test_logic_hold();
        test_sw_priority();
        test_branch_sweep();
        test_reset_clears();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
